// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
// Request fields are combinational from the stage; ack/rdata come back from memory.
interface mem_access_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB register: byte-lane bus access with timeout, load
// extension, write-back select, and stall generation while an access is open.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                MEM_PC,
  input  logic [4:0]                 MEM_rd,
  input  logic [31:0]                MEM_RD2,
  input  logic [2:0]                 MEM_dm_ctrl,
  input  logic                       MEM_RegWrite,
  input  logic                       MEM_mem_w,
  input  logic [31:0]                MEM_aluout,
  input  logic [1:0]                 MEM_WDSel,
  output logic                       mem_stall,
  output logic                       mem_misalign,
  output logic                       mem_bus_err,
  mem_access_stage_if.master         dbus,
  output logic [31:0]                WB_PC,
  output logic [4:0]                 WB_rd,
  output logic                       WB_RegWrite,
  output logic [31:0]                WB_wd
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misalign_q;
  logic [31:0]   wb_pc_q, wb_wd_q;
  logic [4:0]    wb_rd_q;
  logic          wb_regwrite_q;

  logic          is_access_s;
  logic          misaligned_s;
  logic          req_s;
  logic          bubble_s;
  logic [1:0]    ofs_s;
  logic [7:0]    lane_byte_s;
  logic [15:0]   lane_half_s;
  logic [31:0]   load_data_s;
  logic [31:0]   wd_s;
  logic [3:0]   be_s;
  logic [31:0]   wdata_s;

  assign ofs_s       = MEM_aluout[1:0];
  assign is_access_s = (MEM_WDSel == 2'b01 && MEM_RegWrite) || MEM_mem_w;

  // Alignment check by access size; undefined size codes are treated as word.
  always_comb begin
    misaligned_s = 1'b0;
    case (MEM_dm_ctrl)
      3'b001, 3'b010: misaligned_s = ofs_s[0];
      3'b011, 3'b100: misaligned_s = 1'b0;
      default:        misaligned_s = (ofs_s != 2'b00);
    endcase
  end

  // Reset gating makes the request drop the instant reset_n falls.
  assign req_s     = is_access_s & ~misaligned_s & (state_q != S_ABORT) & reset_n;
  assign mem_stall = req_s & ~dbus.dbus_ack;
  assign bubble_s  = mem_stall | (state_q == S_ABORT) | (is_access_s & misaligned_s);

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = MEM_RD2;
    if (MEM_mem_w) begin
      case (MEM_dm_ctrl)
        3'b001, 3'b010: begin
          be_s    = ofs_s[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{MEM_RD2[15:0]}};
        end
        3'b011, 3'b100: begin
          be_s    = 4'b0001 << ofs_s;
          wdata_s = {4{MEM_RD2[7:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = MEM_RD2;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = MEM_RD2;
    end
  end

  assign dbus.dbus_req   = req_s;
  assign dbus.dbus_we    = MEM_mem_w;
  assign dbus.dbus_addr  = {MEM_aluout[31:2], 2'b00};
  assign dbus.dbus_be    = be_s;
  assign dbus.dbus_wdata = wdata_s;

  // Load lane select and sign/zero extension.
  always_comb begin
    lane_byte_s = 8'h00;
    case (ofs_s)
      2'd0:    lane_byte_s = dbus.dbus_rdata[7:0];
      2'd1:    lane_byte_s = dbus.dbus_rdata[15:8];
      2'd2:    lane_byte_s = dbus.dbus_rdata[23:16];
      2'd3:    lane_byte_s = dbus.dbus_rdata[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    lane_half_s = ofs_s[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
    case (MEM_dm_ctrl)
      3'b001:  load_data_s = {{16{lane_half_s[15]}}, lane_half_s};
      3'b010:  load_data_s = {16'h0000, lane_half_s};
      3'b011:  load_data_s = {{24{lane_byte_s[7]}}, lane_byte_s};
      3'b100:  load_data_s = {24'h000000, lane_byte_s};
      default: load_data_s = dbus.dbus_rdata;
    endcase
  end

  // Write-back source select; code 11 falls back to the ALU result.
  always_comb begin
    wd_s = MEM_aluout;
    case (MEM_WDSel)
      2'b01:   wd_s = load_data_s;
      2'b10:   wd_s = MEM_PC + 32'd4;
      default: wd_s = MEM_aluout;
    endcase
  end

  // Access FSM next state; cnt counts stalled cycles so abort follows exactly TIMEOUT of them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s && !dbus.dbus_ack) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = CW'(0);
        end
      end
      S_WAIT: begin
        if (dbus.dbus_ack) begin
          state_d = S_IDLE;
          cnt_d   = CW'(0);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
          cnt_d   = CW'(0);
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CW'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register; a bubble clears only the write enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_pc_q       <= 32'h0000_0000;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_wd_q       <= 32'h0000_0000;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= is_access_s & misaligned_s & (state_q != S_ABORT);
      if (bubble_s) begin
        wb_regwrite_q <= 1'b0;
      end else begin
        wb_pc_q       <= MEM_PC;
        wb_rd_q       <= MEM_rd;
        wb_regwrite_q <= MEM_RegWrite;
        wb_wd_q       <= wd_s;
      end
    end
  end

  assign WB_PC        = wb_pc_q;
  assign WB_rd        = wb_rd_q;
  assign WB_RegWrite  = wb_regwrite_q;
  assign WB_wd        = wb_wd_q;
  assign mem_misalign = misalign_q;
  assign mem_bus_err  = (state_q == S_ABORT);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected write-backs into
// a queue, a negedge monitor pops and compares each WB write.
module tb_mem_access_stage;
  logic        clk;
  logic        reset_n;
  logic [31:0] MEM_PC, MEM_RD2, MEM_aluout;
  logic [4:0]  MEM_rd;
  logic [2:0]  MEM_dm_ctrl;
  logic        MEM_RegWrite, MEM_mem_w;
  logic [1:0]  MEM_WDSel;
  logic        mem_stall, mem_misalign, mem_bus_err;
  logic [31:0] WB_PC, WB_wd;
  logic [4:0]  WB_rd;
  logic        WB_RegWrite;

  mem_access_stage_if dbus();

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .MEM_PC(MEM_PC), .MEM_rd(MEM_rd), .MEM_RD2(MEM_RD2), .MEM_dm_ctrl(MEM_dm_ctrl),
    .MEM_RegWrite(MEM_RegWrite), .MEM_mem_w(MEM_mem_w), .MEM_aluout(MEM_aluout),
    .MEM_WDSel(MEM_WDSel),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err),
    .dbus(dbus),
    .WB_PC(WB_PC), .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite), .WB_wd(WB_wd)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: each WB write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && WB_RegWrite) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got pc=%h wd=%h expected no write", WB_PC, WB_wd);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_pc", WB_PC, e.pc);
        chk("wb_rd", {27'd0, WB_rd}, {27'd0, e.rd});
        chk("wb_wd", WB_wd, e.wd);
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rd2,
                       input logic [2:0] ctrl, input logic regw, input logic memw,
                       input logic [31:0] alu, input logic [1:0] wdsel);
    MEM_PC = pc; MEM_rd = rd; MEM_RD2 = rd2; MEM_dm_ctrl = ctrl;
    MEM_RegWrite = regw; MEM_mem_w = memw; MEM_aluout = alu; MEM_WDSel = wdsel;
  endtask

  task automatic nop();
    drive(32'h0000_0F00, 5'd0, 32'd0, 3'b000, 1'b0, 1'b0, 32'd0, 2'b00);
    dbus.dbus_ack = 1'b0;
  endtask

  // Presents an instruction, acks after ack_delay cycles, checks stall count
  // and (optionally) the bus request fields in the first cycle.
  task automatic run_access(input string nm, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] rd2, input logic [2:0] ctrl, input logic regw,
                            input logic memw, input logic [31:0] alu, input logic [1:0] wdsel,
                            input int ack_delay, input logic [31:0] rdata, input int exp_stall,
                            input bit chk_bus, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int stalls = 0;
    drive(pc, rd, rd2, ctrl, regw, memw, alu, wdsel);
    dbus.dbus_rdata = rdata;
    for (int c = 0; c <= ack_delay; c++) begin
      dbus.dbus_ack = (c == ack_delay);
      @(negedge clk);
      if (mem_stall) stalls++;
      if (chk_bus && c == 0) begin
        chk({nm, "_req"}, {31'd0, dbus.dbus_req}, 32'd1);
        chk({nm, "_we"}, {31'd0, dbus.dbus_we}, {31'd0, memw});
        chk({nm, "_addr"}, dbus.dbus_addr, {alu[31:2], 2'b00});
        chk({nm, "_be"}, {28'd0, dbus.dbus_be}, {28'd0, exp_be});
        if (memw) chk({nm, "_wdata"}, dbus.dbus_wdata, exp_wdata);
      end
      @(posedge clk); #1;
    end
    nop();
    chk({nm, "_stalls"}, stalls, exp_stall);
  endtask

  task automatic run_misaligned(input string nm, input logic [2:0] ctrl, input logic [31:0] alu);
    drive(32'h0000_7000, 5'd3, 32'd0, ctrl, 1'b1, 1'b0, alu, 2'b01);
    dbus.dbus_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_req"}, {31'd0, dbus.dbus_req}, 32'd0);
    chk({nm, "_stall"}, {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, mem_misalign}, 32'd1);
    chk({nm, "_wb_bubble"}, {31'd0, WB_RegWrite}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_pulse_end"}, {31'd0, mem_misalign}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int stalls;
    reset_n = 1'b0;
    nop();
    dbus.dbus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_pc", WB_PC, 32'd0);
    chk("rst_wb_rd", {27'd0, WB_rd}, 32'd0);
    chk("rst_wb_regwrite", {31'd0, WB_RegWrite}, 32'd0);
    chk("rst_wb_wd", WB_wd, 32'd0);
    chk("rst_misalign", {31'd0, mem_misalign}, 32'd0);
    chk("rst_bus_err", {31'd0, mem_bus_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Loads: zero-stall word, delayed byte/half with extension
    exp_q.push_back('{32'h0000_1000, 5'd5, 32'hDEAD_BEEF});
    run_access("lw0", 32'h0000_1000, 5'd5, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0100, 2'b01,
               0, 32'hDEAD_BEEF, 0, 1'b1, 4'b1111, 32'd0);
    exp_q.push_back('{32'h0000_1004, 5'd6, 32'hFFFF_FF80});
    run_access("lb", 32'h0000_1004, 5'd6, 32'd0, 3'b011, 1'b1, 1'b0, 32'h0000_0103, 2'b01,
               3, 32'h8012_3456, 3, 1'b1, 4'b1111, 32'd0);
    exp_q.push_back('{32'h0000_1008, 5'd7, 32'h0000_0080});
    run_access("lbu", 32'h0000_1008, 5'd7, 32'd0, 3'b100, 1'b1, 1'b0, 32'h0000_0103, 2'b01,
               3, 32'h8012_3456, 3, 1'b1, 4'b1111, 32'd0);
    exp_q.push_back('{32'h0000_100C, 5'd8, 32'hFFFF_8001});
    run_access("lh", 32'h0000_100C, 5'd8, 32'd0, 3'b001, 1'b1, 1'b0, 32'h0000_0102, 2'b01,
               1, 32'h8001_5555, 1, 1'b1, 4'b1111, 32'd0);
    exp_q.push_back('{32'h0000_1010, 5'd9, 32'h0000_F00D});
    run_access("lhu", 32'h0000_1010, 5'd9, 32'd0, 3'b010, 1'b1, 1'b0, 32'h0000_0100, 2'b01,
               0, 32'h1234_F00D, 0, 1'b1, 4'b1111, 32'd0);

    // Non-memory write-back sources, including PC+4 wrap and WDSel=11
    exp_q.push_back('{32'h0000_1014, 5'd10, 32'hCAFE_F00D});
    run_access("alu", 32'h0000_1014, 5'd10, 32'd0, 3'b000, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00,
               0, 32'd0, 0, 1'b0, 4'b1111, 32'd0);
    exp_q.push_back('{32'hFFFF_FFFC, 5'd1, 32'h0000_0000});
    run_access("jal", 32'hFFFF_FFFC, 5'd1, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0044, 2'b10,
               0, 32'd0, 0, 1'b0, 4'b1111, 32'd0);
    exp_q.push_back('{32'h0000_1018, 5'd11, 32'h0000_0123});
    run_access("wdsel3", 32'h0000_1018, 5'd11, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0123, 2'b11,
               0, 32'd0, 0, 1'b0, 4'b1111, 32'd0);

    // Stores: lane enables and replication, no write-back
    run_access("sh", 32'h0000_2000, 5'd0, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 32'h0000_0202, 2'b00,
               0, 32'd0, 0, 1'b1, 4'b1100, 32'hABCD_ABCD);
    run_access("sb", 32'h0000_2004, 5'd0, 32'h1234_5677, 3'b011, 1'b0, 1'b1, 32'h0000_0201, 2'b00,
               1, 32'd0, 1, 1'b1, 4'b0010, 32'h7777_7777);
    run_access("sw", 32'h0000_2008, 5'd0, 32'h0BAD_F00D, 3'b000, 1'b0, 1'b1, 32'h0000_0300, 2'b00,
               0, 32'd0, 0, 1'b1, 4'b1111, 32'h0BAD_F00D);

    // Misaligned accesses are dropped
    run_misaligned("mis_lw", 3'b000, 32'h0000_0101);
    run_misaligned("mis_lh", 3'b001, 32'h0000_0203);

    // Timeout: TIMEOUT stall cycles, then one abort cycle
    drive(32'h0000_5000, 5'd12, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0400, 2'b01);
    dbus.dbus_ack = 1'b0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_stall) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        chk("abort_bus_err", {31'd0, mem_bus_err}, 32'd1);
        chk("abort_req", {31'd0, dbus.dbus_req}, 32'd0);
        break;
      end
    end
    chk("timeout_stalls", stalls, 32'd16);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk("abort_end_bus_err", {31'd0, mem_bus_err}, 32'd0);
    chk("abort_wb_bubble", {31'd0, WB_RegWrite}, 32'd0);
    @(posedge clk); #1;
    exp_q.push_back('{32'h0000_5004, 5'd13, 32'h5555_AAAA});
    run_access("lw_after_abort", 32'h0000_5004, 5'd13, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0404,
               2'b01, 2, 32'h5555_AAAA, 2, 1'b1, 4'b1111, 32'd0);

    // Reset in the middle of WAIT, then the held load reissues
    drive(32'h0000_6000, 5'd14, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0500, 2'b01);
    dbus.dbus_ack = 1'b0;
    stalls = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      @(posedge clk); #1;
    end
    chk("prereset_stalls", stalls, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, dbus.dbus_req}, 32'd0);
    chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
    chk("midrst_wb_pc", WB_PC, 32'd0);
    chk("midrst_wb_regwrite", {31'd0, WB_RegWrite}, 32'd0);
    chk("midrst_wb_wd", WB_wd, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('{32'h0000_6000, 5'd14, 32'h1122_3344});
    run_access("lw_reissue", 32'h0000_6000, 5'd14, 32'd0, 3'b000, 1'b1, 1'b0, 32'h0000_0500,
               2'b01, 2, 32'h1122_3344, 2, 1'b1, 4'b1111, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
